// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order RV16I pipeline.
// Tracks outstanding loads in a per-register scoreboard so data memory may
// take any number of cycles, forwards MW writeback data into DE operands,
// stalls DE on RAW/WAW hazards against pending loads, gates control-transfer
// flushes behind stalls, and keeps a saturating stall counter plus a sticky
// watchdog that fires after STALL_MAX consecutive stall cycles.
module pipe_hazard_ctrl #(
   parameter int XLEN      = 16,
   parameter int NREG      = 8,
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 255,
   localparam int AW       = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             de_valid_i,
   input  logic [AW-1:0]    de_rs1_addr_i,
   input  logic [AW-1:0]    de_rs2_addr_i,
   input  logic             de_rs1_used_i,
   input  logic             de_rs2_used_i,
   input  logic [XLEN-1:0]  de_rs1_data_i,
   input  logic [XLEN-1:0]  de_rs2_data_i,
   input  logic [AW-1:0]    de_rd_addr_i,
   input  logic             de_wr_en_i,
   input  logic             de_load_i,
   input  logic             de_redirect_i,
   input  logic             mw_wr_en_i,
   input  logic [AW-1:0]    mw_rd_addr_i,
   input  logic [XLEN-1:0]  mw_wr_data_i,
   input  logic             mw_load_i,
   output logic [XLEN-1:0]  rs1_data_o,
   output logic [XLEN-1:0]  rs2_data_o,
   output logic             stall_o,
   output logic             if_de_flush_o,
   output logic             de_mw_flush_o,
   output logic [NREG-1:0]  busy_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             stall_timeout_o
);

   // Watchdog is a down-counter reloaded on every non-stall cycle; it fires
   // when a stall cycle is taken with one count left.
   localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(STALL_MAX);

   logic [NREG-1:0]  busy_q, busy_d;
   logic [NREG-1:0]  set_vec, clr_vec;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             timeout_q, timeout_d;

   logic             match_rs1, match_rs2;
   logic             haz_rs1, haz_rs2, haz_waw;
   logic             ld_clr_rd;
   logic             stall;
   logic             ld_issue;

   // Operand forwarding: MW writeback overrides the regfile read; x0 reads zero.
   always_comb begin
      match_rs1  = mw_wr_en_i && (mw_rd_addr_i == de_rs1_addr_i) && (de_rs1_addr_i != '0);
      match_rs2  = mw_wr_en_i && (mw_rd_addr_i == de_rs2_addr_i) && (de_rs2_addr_i != '0);
      rs1_data_o = de_rs1_data_i;
      rs2_data_o = de_rs2_data_i;
      if (de_rs1_addr_i == '0) begin
         rs1_data_o = '0;
      end else if (match_rs1) begin
         rs1_data_o = mw_wr_data_i;
      end
      if (de_rs2_addr_i == '0) begin
         rs2_data_o = '0;
      end else if (match_rs2) begin
         rs2_data_o = mw_wr_data_i;
      end
   end

   // Hazard detection; load data returning this cycle is forwarded, not stalled on.
   always_comb begin
      haz_rs1   = de_valid_i && de_rs1_used_i && busy_q[de_rs1_addr_i]
                  && !(match_rs1 && mw_load_i);
      haz_rs2   = de_valid_i && de_rs2_used_i && busy_q[de_rs2_addr_i]
                  && !(match_rs2 && mw_load_i);
      ld_clr_rd = mw_wr_en_i && mw_load_i && (mw_rd_addr_i == de_rd_addr_i);
      haz_waw   = de_valid_i && de_load_i && de_wr_en_i && busy_q[de_rd_addr_i]
                  && !ld_clr_rd;
      stall     = haz_rs1 || haz_rs2 || haz_waw;
      ld_issue  = de_valid_i && de_load_i && de_wr_en_i && !stall
                  && (de_rd_addr_i != '0);
   end

   // Pipeline control outputs; a redirect waits until DE is no longer stalled.
   always_comb begin
      stall_o         = stall;
      de_mw_flush_o   = stall;
      if_de_flush_o   = de_valid_i && de_redirect_i && !stall;
      busy_o          = busy_q;
      stall_cnt_o     = stall_cnt_q;
      stall_timeout_o = timeout_q;
   end

   // Scoreboard next state: issue sets win over same-cycle clears; x0 never busy.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (ld_issue) begin
         set_vec[de_rd_addr_i] = 1'b1;
      end
      if (mw_wr_en_i && mw_load_i) begin
         clr_vec[mw_rd_addr_i] = 1'b1;
      end
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
   end

   // Saturating stall counter and stall-run watchdog next state.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      wd_d        = WD_LOAD;
      timeout_d   = timeout_q;
      if (stall) begin
         if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (wd_q != '0) begin
            wd_d = wd_q - CNT_W'(1);
         end else begin
            wd_d = '0;
         end
         if (wd_q == CNT_W'(1)) begin
            timeout_d = 1'b1;
         end
      end
   end

   // State registers; reset empties the scoreboard and clears all counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         stall_cnt_q <= '0;
         wd_q        <= WD_LOAD;
         timeout_q   <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RV16I pipeline. It replaces the fixed-function hazard detection sitting between decode/execute (DE) and memory/writeback (MW). It keeps a per-register scoreboard of outstanding loads, so it supports multi-cycle data memory. It also provides MW→DE operand forwarding, control-transfer flushes, bubble insertion, a stall performance counter and a stall watchdog.

## Interface
Parameters:
- XLEN, 16, datapath width
- NREG, 8, architectural registers; AW = $clog2(NREG); register 0 is hard-wired zero
- CNT_W, 16, width of stall performance counter
- STALL_MAX, 255, consecutive stall cycles before watchdog fires (1..2^CNT_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- de_valid_i  in  1  DE holds a valid instruction
- de_rs1_addr_i, de_rs2_addr_i  in  AW  DE source registers
- de_rs1_used_i, de_rs2_used_i  in  1  source actually read
- de_rs1_data_i, de_rs2_data_i  in  XLEN  regfile read data
- de_rd_addr_i  in  AW  DE destination
- de_wr_en_i  in  1  DE instruction writes rd
- de_load_i  in  1  DE instruction is a load
- de_redirect_i  in  1  taken branch/jal/jalr resolved in DE
- mw_wr_en_i  in  1  MW writeback valid this cycle
- mw_rd_addr_i  in  AW  MW destination
- mw_wr_data_i  in  XLEN  MW writeback data
- mw_load_i  in  1  MW writeback is load data
- rs1_data_o, rs2_data_o  out  XLEN  forwarded operands to ALU
- stall_o  out  1  hold PC and IF/DE
- if_de_flush_o  out  1  squash IF/DE
- de_mw_flush_o  out  1  insert bubble into DE/MW
- busy_o  out  NREG  scoreboard contents
- stall_cnt_o  out  CNT_W  saturating total stall cycles
- stall_timeout_o  out  1  sticky watchdog flag

## Operation
- Scoreboard busy[NREG]: a bit is set on load issue, i.e. de_valid_i & de_load_i & de_wr_en_i & !stall_o & rd≠0. The bit clears on mw_wr_en_i & mw_load_i for mw_rd_addr_i. busy[0] is always 0.
- Same-cycle set and clear of one register: set wins.
- A clear for a non-busy register is ignored.
- Forward match rsN: mw_wr_en_i & mw_rd_addr_i==rsN & rsN≠0.
  - rsN_data_o = mw_wr_data_i on a match.
  - Otherwise rsN_data_o = de_rsN_data_i.
  - If rsN==0, the output is forced to 0.
- Hazard on rsN: de_valid_i & de_rsN_used_i & busy[rsN] & !(match on rsN & mw_load_i). Load data arriving this cycle is forwarded rather than stalled on.
- WAW hazard: de_valid_i & de_load_i & de_wr_en_i & busy[rd] & !(load clear of rd this cycle).
- stall_o = any rs hazard | WAW hazard.
- de_mw_flush_o = stall_o.
- if_de_flush_o = de_valid_i & de_redirect_i & !stall_o. A redirect is held off while stalled and honoured in the first unstalled cycle.
- stall_cnt_o increments on every stall_o cycle and saturates at all-ones.
- Watchdog: a run counter counts consecutive stall_o cycles and resets on any non-stall cycle. When the run reaches STALL_MAX, stall_timeout_o is set. It stays set until reset.

## Timing
- All decisions are combinational from registered state (busy, counters) plus current inputs. There is zero-cycle latency from inputs to stall_o, the flushes and the forwarded data.
- busy_o, stall_cnt_o and stall_timeout_o update on posedge clk.
- Load-to-use with 1-cycle memory: one stall cycle, then forward in the cycle data returns. With L-cycle memory: L stall cycles.
- Reset mid-operation:
  - busy clears immediately (async); counters and the sticky flag go to 0.
  - Outputs during reset: busy_o=0, stall_cnt_o=0, stall_timeout_o=0.
  - stall_o=0, because busy is empty and mw-clear is irrelevant.
  - Flush and data outputs follow the combinational rules.
- Multiple outstanding loads to distinct registers are allowed, up to NREG-1.
- Writes to x0 never set busy and are never forwarded.

## Test plan
- Load r3 issues, next cycle add r4=r3+r1 with 2-cycle memory → stall_o=1 for 2 cycles. Then mw_load_i with rd=3, data 0x00A5 → rs1_data_o=0x00A5, stall_o=0, busy[3]→0.
- ALU writeback r2=0x1234 in MW while DE reads r2 → rs2_data_o=0x1234, no stall. With rd=0 instead → rs2_data_o=0.
- Taken branch in DE while unstalled → if_de_flush_o=1 for one cycle. Same branch while a hazard is pending → flush deferred to the first cycle stall_o=0.
- Load r5 outstanding, second load to r5 in DE → WAW stall until the r5 clear. Clear and new issue in the same cycle → busy[5] stays 1.
- Never return the load, STALL_MAX=4 → stall_timeout_o=1 after the 4th consecutive stall cycle, and stall_cnt_o=4 at that point. Assert rst_n=0 asynchronously mid-cycle → busy_o=0, stall_cnt_o=0, flag=0 immediately.
- Force 2^CNT_W+3 stall cycles with CNT_W=4 → stall_cnt_o holds 4'hF.
